// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    // FETCH: idle, may issue; WAIT: live request; DROP: request whose data is stale
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Generic circular FIFO with synchronous flush and occupancy count.
// Latency: pushed entry visible at head the cycle after the push.
// Backpressure: pushes are ignored when full; head held until pop_rdy.
// Ports: clock/reset, flush (empties queue), push_vld/push_dat,
//        pop_rdy (consumer takes head), head_vld/head_dat, count.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_push  = push_vld && !flush && (count != FULL);
    assign do_pop   = pop_rdy && head_vld;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: one outstanding memory read feeding a small queue.
// Latency: request one cycle after space is free; data at head the cycle after ack.
// Backpressure: consumer stalls via out_ready; fetching stops when queue+request fill DEPTH.
// Ports: clock/reset; imem_req/imem_addr/imem_ack/imem_rdata (memory side);
//        redirect_valid/redirect_addr (flush + new target);
//        out_valid/out_ready/out_instr/out_pc/out_link_addr (consumer side).
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [ADDR_W-1:0]   out_link_addr
);

    localparam int ENT_W = ADDR_W + INSTR_W;

    fetch_state_t               state;
    fetch_state_t               state_nxt;
    logic [ADDR_W-1:0]          pc;
    logic                       push;
    logic                       pending;
    logic                       has_space;
    logic [$clog2(DEPTH):0]     q_count;
    logic [ENT_W-1:0]           head_dat;
    logic                       redirect_lsb_unused;

    // Fetch targets are always word aligned; the low bits are dropped.
    assign redirect_lsb_unused = ^redirect_addr[1:0];

    assign imem_req  = (state != FETCH);
    // A live request already owns a slot so its ack can never overflow.
    assign pending   = (state == WAIT);
    assign has_space = (int'(q_count) + int'(pending)) < DEPTH;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            FETCH: begin
                if (!redirect_valid && has_space) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_ack) begin
                    state_nxt = FETCH;
                    push      = !redirect_valid;
                end else if (redirect_valid) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                // Stale data is absorbed here; redirects only move pc.
                if (imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            imem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && state_nxt == WAIT) imem_addr <= pc;
            if (redirect_valid)
                pc <= {redirect_addr[ADDR_W-1:2], 2'b00};
            else if (push)
                pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat ({pc, imem_rdata}),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (head_dat),
        .count    (q_count)
    );

    assign out_pc        = head_dat[ENT_W-1:INSTR_W];
    assign out_instr     = head_dat[INSTR_W-1:0];
    assign out_link_addr = out_pc + ADDR_W'(PC_STEP);

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_link_addr;

    logic        reset8;
    logic        req8;
    logic [7:0]  addr8;
    logic        ack8;
    logic [31:0] rdata8;
    logic        redirect8;
    logic [7:0]  redirect_addr8;
    logic        valid8;
    logic        ready8;
    logic [31:0] instr8;
    logic [7:0]  pc8;
    logic [7:0]  link8;

    ifetch_prefetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_link_addr(out_link_addr)
    );

    // Narrow instance with a zero-latency memory to exercise pc wrap-around.
    ifetch_prefetch #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'hFC)) dut8 (
        .clock(clock), .reset(reset8),
        .imem_req(req8), .imem_addr(addr8),
        .imem_ack(ack8), .imem_rdata(rdata8),
        .redirect_valid(redirect8), .redirect_addr(redirect_addr8),
        .out_valid(valid8), .out_ready(ready8),
        .out_instr(instr8), .out_pc(pc8), .out_link_addr(link8)
    );

    assign ack8   = req8;
    assign rdata8 = {24'h0, addr8};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Reference model state: expected queue contents in program order.
    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        q[$];
    logic [31:0] pop_log[$];
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    bit          outstanding;
    bit          live;
    bit          ack_auto;
    int          lat;
    int          lat_min;
    int          lat_max;
    int          n_push;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies the effect of the coming clock edge to the model, then checks the DUT.
    task automatic tick();
        bit accept;
        if (reset) begin
            q.delete();
            fetch_pc    = 32'h0;
            outstanding = 0;
            live        = 0;
        end else begin
            accept = imem_ack && outstanding && live && !redirect_valid;
            if (redirect_valid) begin
                q.delete();
                fetch_pc = {redirect_addr[31:2], 2'b00};
                live     = 0;
            end else begin
                if (q.size() > 0 && out_ready) begin
                    pop_log.push_back(q[0].pc);
                    void'(q.pop_front());
                end
                if (accept) begin
                    q.push_back('{pc: req_addr, instr: imem_rdata});
                    fetch_pc = fetch_pc + 32'd4;
                    n_push++;
                end
            end
            if (outstanding) begin
                if (imem_ack) outstanding = 0;
                else if (lat > 0) lat--;
            end
        end
        @(posedge clock);
        #1;
        if (outstanding) begin
            check("req_held", imem_req, 1);
            check("addr_stable", imem_addr, req_addr);
        end else if (imem_req) begin
            check("req_addr", imem_addr, fetch_pc);
            outstanding = 1;
            live        = 1;
            req_addr    = fetch_pc;
            lat         = $urandom_range(lat_max, lat_min);
        end
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", out_instr, q[0].instr);
            check("out_link", out_link_addr, q[0].pc + 32'd4);
        end
        check("no_overflow", q.size() > 4, 0);
    endtask

    task automatic step();
        if (ack_auto) begin
            imem_ack   = outstanding && (lat == 0);
            imem_rdata = $urandom;
        end
        tick();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        step();
        step();
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", out_valid, 0);
        reset = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 40) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, imem_req, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid_seen"}, out_valid, 1);
    endtask

    initial begin
        logic [7:0]  pcs8[$];
        logic [31:0] instrs8[$];
        logic [7:0]  link8_first;
        int          n;

        reset = 1'b1; reset8 = 1'b1; redirect8 = 1'b0; redirect_addr8 = 8'h0; ready8 = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0; redirect_addr = 32'h0;
        out_ready = 1'b1; ack_auto = 1; lat_min = 1; lat_max = 1; n_push = 0;
        fetch_pc = 32'h0; req_addr = 32'h0; outstanding = 0; live = 0; lat = 0;

        // Reset release, first request in the second cycle, 0,4,8,12 stream.
        do_reset();
        step();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 32'h0);
        pop_log.delete();
        n = 0;
        while (pop_log.size() < 4 && n < 60) begin
            step();
            n++;
        end
        check("seq_len", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("seq_pc", pop_log[i], 32'(i * 4));

        // Stalled consumer: exactly DEPTH pushes, then fetching stops.
        do_reset();
        out_ready = 1'b0; lat_min = 0; lat_max = 0; n_push = 0;
        repeat (30) step();
        check("stall_pushes", n_push, 4);
        check("stall_req", imem_req, 0);
        check("stall_head_pc", out_pc, 32'h0);
        if (q.size() > 0) check("stall_head_instr", out_instr, q[0].instr);
        out_ready = 1'b1;
        repeat (6) step();

        // Redirect during WAIT; the late ack is dropped.
        do_reset();
        ack_auto = 0;
        wait_req("drop");
        redirect_valid = 1'b1; redirect_addr = 32'h100;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("drop_no_valid", out_valid, 0);
        wait_req("drop2");
        check("drop_new_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;
        wait_valid("drop3");
        check("drop_first_pc", out_pc, 32'h100);

        // Redirect coincident with ack and a pop: queue flushed, aligned target.
        do_reset();
        out_ready = 1'b0;
        wait_req("coin");
        imem_ack = 1'b1; imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;
        wait_req("coin2");
        check("coin_q_busy", out_valid, 1);
        imem_ack = 1'b1; imem_rdata = $urandom;
        redirect_valid = 1'b1; redirect_addr = 32'h203; out_ready = 1'b1;
        step();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        check("coin_empty", out_valid, 0);
        wait_req("coin3");
        check("coin_addr", imem_addr, 32'h200);
        imem_ack = 1'b1; imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;

        // Reset while WAIT; a stray ack right after reset is ignored.
        do_reset();
        wait_req("rstw");
        reset = 1'b1;
        step();
        check("rstw_req", imem_req, 0);
        check("rstw_valid", out_valid, 0);
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        check("rstw_req_again", imem_req, 1);
        check("rstw_addr", imem_addr, 32'h0);
        check("rstw_no_push", out_valid, 0);
        imem_ack = 1'b1; imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        ack_auto = 1; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_addr  = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'h3FF);
            reset          = ($urandom % 400) == 0;
            step();
        end
        reset = 1'b0; redirect_valid = 1'b0;

        // Narrow instance: pc wraps from 0xFC to 0x00.
        reset = 1'b1;
        step();
        step();
        reset8 = 1'b0;
        n = 0;
        link8_first = 8'h0;
        while (pcs8.size() < 2 && n < 40) begin
            step();
            if (valid8) begin
                if (pcs8.size() == 0) link8_first = link8;
                pcs8.push_back(pc8);
                instrs8.push_back(instr8);
            end
            n++;
        end
        check("wrap_count", pcs8.size(), 2);
        if (pcs8.size() == 2) begin
            check("wrap_pc0", pcs8[0], 8'hFC);
            check("wrap_pc1", pcs8[1], 8'h00);
            check("wrap_instr0", instrs8[0], 32'h0000_00FC);
            check("wrap_link0", link8_first, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, fetch address after reset; word-aligned.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port imem_req  out  1  fetch request outstanding.
REQ-007 SHALL have port imem_addr  out  ADDR_W  word address of the outstanding request.
REQ-008 SHALL have port imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-009 SHALL have port imem_rdata  in  32  instruction word.
REQ-010 SHALL have port redirect_valid  in  1  branch/jump/jr taken; flush and refetch.
REQ-011 SHALL have port redirect_addr  in  ADDR_W  new fetch target.
REQ-012 SHALL have port out_valid  out  1  queue head valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts the head.
REQ-014 SHALL have port out_instr  out  32  head instruction.
REQ-015 SHALL have port out_pc  out  ADDR_W  PC of the head instruction.
REQ-016 SHALL have port out_link_addr  out  ADDR_W  out_pc+4 for jal and branch base.

Function
REQ-017 SHALL implement FSM states FETCH, WAIT and DROP.
REQ-018 SHALL keep imem_req = (state != FETCH), with imem_addr registered and stable while imem_req is high.
REQ-019 SHALL go FETCH->WAIT and latch imem_addr=pc when count+pending < DEPTH and redirect_valid=0.
REQ-020 SHALL, on imem_ack in WAIT, push {pc, imem_rdata}, set pc=pc+4 (modulo 2^ADDR_W, wrapping silently) and return to FETCH.
REQ-021 SHALL give a maximum throughput of one instruction per two cycles at zero memory latency.
REQ-022 SHALL, on redirect_valid in any state, clear the queue (out_valid=0 next cycle) and load pc={redirect_addr[ADDR_W-1:2],2'b00}.
REQ-023 SHALL, on redirect in WAIT without ack, enter DROP; in DROP, the eventual ack data is discarded, no push occurs, and the FSM enters FETCH.
REQ-024 SHALL, on redirect coincident with ack (WAIT or DROP), discard the ack data and enter FETCH.
REQ-025 SHALL, on redirect in DROP, update pc only and stay in DROP.
REQ-026 SHALL complete a head transfer when out_valid & out_ready; simultaneous push and pop leaves count unchanged.
REQ-027 SHALL let redirect take priority over push and pop in the same cycle; the queue is empty afterward.
REQ-028 SHALL drive out_instr/out_pc directly from the head register with no extra cycle; out_link_addr = out_pc+4 combinationally.
REQ-029 SHALL never overflow: the reservation in REQ-019 guarantees space for every accepted ack.
REQ-030 SHALL hold the head while out_valid=1 and out_ready=0.

Reset
REQ-031 SHALL reset pc=RESET_PC, state=FETCH, queue empty, out_valid=0, imem_req=0 and imem_addr=0.
REQ-032 SHALL assert the first imem_req with imem_addr=RESET_PC in the second cycle after reset falls.
REQ-033 SHALL let reset mid-transaction abandon the outstanding request; a late imem_ack in FETCH is ignored.

Structure
REQ-034 SHALL place state encodings, INSTR_W=32 and PC_STEP=4 in shared package ifetch_pkg.
REQ-035 SHALL implement the queue as sub-module ifetch_fifo (parameter DEPTH, width ADDR_W+32, synchronous flush, count output).

Verification
REQ-036 SHALL cover: reset release with ack one cycle after each req and out_ready=1 -> out_pc sequence 0,4,8,12, with out_link_addr = out_pc+4.
REQ-037 SHALL cover: out_ready=0 with DEPTH=4 -> exactly 4 pushes, imem_req stays 0, and out_instr holds the first word.
REQ-038 SHALL cover: redirect to 0x100 during WAIT, ack three cycles later -> data dropped, next req addr 0x100, and first out_pc=0x100.
REQ-039 SHALL cover: redirect to 0x203 coincident with ack and out_ready -> queue empty, and next imem_addr=0x200.
REQ-040 SHALL cover: ADDR_W=8, RESET_PC=0xFC -> out_pc 0xFC then 0x00.
REQ-041 SHALL cover: reset asserted while in WAIT -> next cycle imem_req=0, out_valid=0, and a later req at RESET_PC.
